// File: rtl/dfersb_bank_if.sv
// dfersb_bank_if: control, data and status bundle for the dfersb_bank register pipeline.
// The master side drives set, enable, mode and data. The slave side (the bank) returns
// Q, QB, SO, VLD and CONF_CNT.
interface dfersb_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             SB;
    logic             EB;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QB;
    logic             SO;
    logic             VLD;
    logic [CNT_W-1:0] CONF_CNT;

    modport master (
        output SB, EB, MODE, D, SI,
        input  Q, QB, SO, VLD, CONF_CNT
    );

    modport slave (
        input  SB, EB, MODE, D, SI,
        output Q, QB, SO, VLD, CONF_CNT
    );
endinterface

// File: rtl/dfersb_bank.sv
// dfersb_bank: WIDTH-bit, DEPTH-stage register pipeline.
// - Active-low enable (EB) and synchronous active-low reset (RB) and set (SB).
// - Tracks a valid bit for each stage.
// - Modes: LOAD, HOLD, SHIFT (serial) and RECIRC.
// - Keeps a registered set/reset conflict flag that forces QB to zero.
// Optional feature: define DFERSB_BANK_CONFLICT_CNT_EN to add a saturating counter of
// edges where RB and SB are both low. Without it, CONF_CNT is tied to zero.
module dfersb_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               CK,
    input  logic               RB,
    dfersb_bank_if.slave       bus
);
    localparam int unsigned ChainW = DEPTH * WIDTH;

    localparam logic [1:0] ModeLoad   = 2'b00;
    localparam logic [1:0] ModeHold   = 2'b01;
    localparam logic [1:0] ModeShift  = 2'b10;
    localparam logic [1:0] ModeRecirc = 2'b11;

    logic [WIDTH-1:0]  r_stage [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic              r_conf;
    logic [ChainW-1:0] w_chain;
    logic [ChainW-1:0] w_shifted;

    // Flatten the stages into one chain (stage 0 is the low end) and shift it left by one.
    always_comb begin
        w_chain = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_chain[i*WIDTH +: WIDTH] = r_stage[i];
        end
        w_shifted = {w_chain[ChainW-2:0], bus.SI};
    end

    // Stage, valid and conflict update. Priority is RB, then SB, then EB, then MODE.
    always_ff @(posedge CK) begin
        if (!RB) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            r_vld  <= '0;
            r_conf <= ~bus.SB;
        end else if (!bus.SB) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '1;
            r_vld  <= '1;
            r_conf <= 1'b0;
        end else if (!bus.EB) begin
            unique case (bus.MODE)
                ModeLoad, ModeRecirc: begin
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                        r_vld[i]   <= r_vld[i-1];
                    end
                    if (bus.MODE == ModeLoad) begin
                        r_stage[0] <= bus.D;
                        r_vld[0]   <= 1'b1;
                    end else begin
                        r_stage[0] <= r_stage[DEPTH-1];
                        r_vld[0]   <= r_vld[DEPTH-1];
                    end
                end
                ModeShift: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= w_shifted[i*WIDTH +: WIDTH];
                    end
                end
                ModeHold: ;
                default: ;
            endcase
        end
    end

`ifdef DFERSB_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Count edges where RB and SB are both low, saturating. Only an edge with RB low alone clears it.
    always_ff @(posedge CK) begin
        if (!RB && !bus.SB) begin
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
        end else if (!RB) begin
            r_cnt <= '0;
        end
    end

    assign bus.CONF_CNT = r_cnt;
`else
    assign bus.CONF_CNT = {CNT_W{1'b0}};
`endif

    assign bus.Q   = r_stage[DEPTH-1];
    assign bus.QB  = r_conf ? '0 : ~r_stage[DEPTH-1];
    assign bus.SO  = r_stage[DEPTH-1][WIDTH-1];
    assign bus.VLD = r_vld[DEPTH-1];
endmodule

// File: tb/tb_dfersb_bank.sv
// tb_dfersb_bank: directed self-checking bench for dfersb_bank with WIDTH=8 and DEPTH=4.
module tb_dfersb_bank;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic CK;
    logic RB;
    int   n_tests;
    int   n_fail;

    dfersb_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    dfersb_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CK  (CK),
        .RB  (RB),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RB = 1'b0; bus.SB = 1'b1; bus.EB = 1'b1;
        tick();
        RB = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (bus.Q !== 8'h00 || bus.QB !== 8'hFF || bus.SO !== 1'b0 || bus.VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: Q=%h QB=%h SO=%b VLD=%b, want Q=00 QB=FF SO=0 VLD=0",
                     bus.Q, bus.QB, bus.SO, bus.VLD);
        end
    endtask

    task automatic test_load();
        logic [7:0] din [7];
        logic [7:0] qexp [7];
        din  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        qexp = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        bus.EB = 1'b0; bus.MODE = 2'b00;
        for (int k = 0; k < 7; k++) begin
            bus.D = din[k];
            tick();
            n_tests++;
            if (bus.Q !== qexp[k] || bus.VLD !== (k >= 3)) begin
                n_fail++;
                $display("FAIL load[%0d]: Q=%h VLD=%b, want Q=%h VLD=%b",
                         k, bus.Q, bus.VLD, qexp[k], (k >= 3));
            end
            if (k == 3) begin
                n_tests++;
                if (bus.QB !== 8'hEE) begin
                    n_fail++;
                    $display("FAIL load_qb: QB=%h, want EE", bus.QB);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.EB = 1'b0; bus.MODE = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            bus.D = 8'(k);
            tick();
        end
        bus.EB = 1'b1;
        bus.D  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (bus.Q !== 8'h01 || bus.VLD !== 1'b1) begin
                n_fail++;
                $display("FAIL stall[%0d]: Q=%h VLD=%b, want Q=01 VLD=1", k, bus.Q, bus.VLD);
            end
        end
        bus.EB = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.D = 8'(5 + k);
            tick();
            n_tests++;
            if (bus.Q !== 8'(2 + k)) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: Q=%h, want %h", k, bus.Q, 8'(2 + k));
            end
        end
        // HOLD with EB low also freezes state.
        bus.MODE = 2'b01;
        tick();
        n_tests++;
        if (bus.Q !== 8'h04) begin
            n_fail++;
            $display("FAIL hold_mode: Q=%h, want 04", bus.Q);
        end
    endtask

    task automatic test_shift();
        do_reset();
        bus.EB = 1'b0; bus.MODE = 2'b10; bus.SI = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            n_tests++;
            if (bus.SO !== (k == 32)) begin
                n_fail++;
                $display("FAIL shift_so[%0d]: SO=%b, want %b", k, bus.SO, (k == 32));
            end
        end
        n_tests++;
        if (bus.Q !== 8'hFF || bus.VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_end: Q=%h VLD=%b, want Q=FF VLD=0", bus.Q, bus.VLD);
        end
        // Shift in a 0: ones move up one bit, and bit 0 of the last stage takes stage 2's MSB (1).
        bus.SI = 1'b0;
        tick();
        n_tests++;
        if (bus.Q !== 8'hFF) begin
            n_fail++;
            $display("FAIL shift_zero: Q=%h, want FF", bus.Q);
        end
    endtask

    task automatic test_recirc();
        logic [7:0] seq [4];
        seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        bus.EB = 1'b0; bus.MODE = 2'b00;
        for (int k = 0; k < 4; k++) begin
            bus.D = seq[k];
            tick();
        end
        bus.MODE = 2'b11;
        bus.D    = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if (bus.Q !== seq[k % 4] || bus.VLD !== 1'b1) begin
                n_fail++;
                $display("FAIL recirc[%0d]: Q=%h VLD=%b, want Q=%h VLD=1",
                         k, bus.Q, bus.VLD, seq[k % 4]);
            end
        end
    endtask

    task automatic test_set_conflict();
        bus.EB = 1'b1;
        RB = 1'b1; bus.SB = 1'b0;
        tick();
        n_tests++;
        if (bus.Q !== 8'hFF || bus.VLD !== 1'b1 || bus.QB !== 8'h00 || bus.SO !== 1'b1) begin
            n_fail++;
            $display("FAIL set: Q=%h VLD=%b QB=%h SO=%b, want FF 1 00 1",
                     bus.Q, bus.VLD, bus.QB, bus.SO);
        end
        RB = 1'b0; bus.SB = 1'b0;
        tick();
        n_tests++;
        if (bus.Q !== 8'h00 || bus.QB !== 8'h00 || bus.VLD !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict: Q=%h QB=%h VLD=%b, want 00 00 0", bus.Q, bus.QB, bus.VLD);
        end
        // The conflict flag persists through normal enabled cycles.
        RB = 1'b1; bus.SB = 1'b1; bus.EB = 1'b0; bus.MODE = 2'b01;
        tick();
        n_tests++;
        if (bus.QB !== 8'h00) begin
            n_fail++;
            $display("FAIL conflict_hold: QB=%h, want 00", bus.QB);
        end
        RB = 1'b0; bus.SB = 1'b1;
        tick();
        RB = 1'b1;
        n_tests++;
        if (bus.QB !== 8'hFF || bus.Q !== 8'h00) begin
            n_fail++;
            $display("FAIL conflict_clear: QB=%h Q=%h, want FF 00", bus.QB, bus.Q);
        end
    endtask

    task automatic test_counter();
        logic [7:0] exp_cnt;
        // Start from a cleared counter.
        RB = 1'b0; bus.SB = 1'b1; bus.EB = 1'b1;
        tick();
        exp_cnt = 8'd0;
        for (int k = 1; k <= 300; k++) begin
            RB = 1'b0; bus.SB = 1'b0;
            tick();
`ifdef DFERSB_BANK_CONFLICT_CNT_EN
            exp_cnt = (k >= 255) ? 8'd255 : 8'(k);
`endif
            if (k == 1 || k == 3 || k == 254 || k == 255 || k == 300) begin
                n_tests++;
                if (bus.CONF_CNT !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL conf_cnt[%0d]: CONF_CNT=%0d, want %0d", k, bus.CONF_CNT, exp_cnt);
                end
            end
        end
        // An edge with SB low alone must not clear the count.
        RB = 1'b1; bus.SB = 1'b0;
        tick();
        n_tests++;
        if (bus.CONF_CNT !== exp_cnt) begin
            n_fail++;
            $display("FAIL conf_cnt_set: CONF_CNT=%0d, want %0d", bus.CONF_CNT, exp_cnt);
        end
        RB = 1'b0; bus.SB = 1'b1;
        tick();
        RB = 1'b1;
        n_tests++;
        if (bus.CONF_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL conf_cnt_clear: CONF_CNT=%0d, want 0", bus.CONF_CNT);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        RB       = 1'b0;
        bus.SB   = 1'b1;
        bus.EB   = 1'b1;
        bus.MODE = 2'b01;
        bus.D    = '0;
        bus.SI   = 1'b0;
        test_reset();
        test_load();
        test_stall();
        test_shift();
        test_recirc();
        test_set_conflict();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
